// File: rtl/register_bank.sv
// Purpose: sixteen N-bit architectural registers with writeback, link (R14) and PC-mirror (R15) ports plus a busy scoreboard.
// Latency: one cycle from any write, reserve or pc_i sample to the outputs; all outputs come straight from flops.
// Backpressure: none; every request is accepted on the edge it is presented.
module register_bank #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [3:0]   waddr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         link_we_i,
    input  logic [N-1:0] link_data_i,
    input  logic [N-1:0] pc_i,
    input  logic         reserve_i,
    input  logic [3:0]   reserve_addr_i,
    output logic [N-1:0] r0_o,
    output logic [N-1:0] r1_o,
    output logic [N-1:0] r2_o,
    output logic [N-1:0] r3_o,
    output logic [N-1:0] r4_o,
    output logic [N-1:0] r5_o,
    output logic [N-1:0] r6_o,
    output logic [N-1:0] r7_o,
    output logic [N-1:0] r8_o,
    output logic [N-1:0] r9_o,
    output logic [N-1:0] r10_o,
    output logic [N-1:0] r11_o,
    output logic [N-1:0] r12_o,
    output logic [N-1:0] r13_o,
    output logic [N-1:0] r14_o,
    output logic [N-1:0] r15_o,
    output logic [15:0]  busy_o
);

    logic [N-1:0] regs [16];
    logic [15:0]  busy_q;
    logic [15:0]  busy_nxt;
    logic [15:0]  set_mask;
    logic [15:0]  clr_mask;

    // A reserve in the same cycle as a writeback belongs to the newer instruction, so set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (reserve_i && reserve_addr_i != 4'd15) set_mask[reserve_addr_i] = 1'b1;
        if (we_i)                                 clr_mask[waddr_i]        = 1'b1;
        if (link_we_i)                            clr_mask[14]             = 1'b1;
        busy_nxt     = set_mask | (busy_q & ~clr_mask);
        busy_nxt[15] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 16; k++) regs[k] <= '0;
            busy_q <= '0;
        end else begin
            for (int k = 0; k < 14; k++) begin
                if (we_i && waddr_i == 4'(k)) regs[k] <= wdata_i;
            end
            if (we_i && waddr_i == 4'd14) regs[14] <= wdata_i;
            else if (link_we_i)           regs[14] <= link_data_i;
            regs[15] <= pc_i;
            busy_q   <= busy_nxt;
        end
    end

    assign r0_o   = regs[0];
    assign r1_o   = regs[1];
    assign r2_o   = regs[2];
    assign r3_o   = regs[3];
    assign r4_o   = regs[4];
    assign r5_o   = regs[5];
    assign r6_o   = regs[6];
    assign r7_o   = regs[7];
    assign r8_o   = regs[8];
    assign r9_o   = regs[9];
    assign r10_o  = regs[10];
    assign r11_o  = regs[11];
    assign r12_o  = regs[12];
    assign r13_o  = regs[13];
    assign r14_o  = regs[14];
    assign r15_o  = regs[15];
    assign busy_o = busy_q;

endmodule

// File: doc/register_bank.md
# register_bank

- Storage stage of the CPU register file: sixteen N-bit architectural registers R0–R15.
- Each register drives its own output bus continuously; the bank sits directly upstream of the 16:1 read multiplexers, so r0_o..r15_o connect to the mux data inputs in order.
- Provides one writeback port, a dedicated link-register (R14) write port and a program-counter mirror in R15.
- Keeps a per-register busy scoreboard so the issue logic can detect pending writes.

## Interface

- N, default 32, register and data width in bits.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- we_i  input  1  writeback enable.
- waddr_i  input  4  writeback destination register.
- wdata_i  input  N  writeback data.
- link_we_i  input  1  link write enable; targets R14.
- link_data_i  input  N  link data (return address).
- pc_i  input  N  current program counter; sampled into R15 every cycle.
- reserve_i  input  1  mark a destination register as pending.
- reserve_addr_i  input  4  register to mark pending.
- r0_o .. r15_o  output  N each  current contents of R0..R15.
- busy_o  output  16  bit k = 1 while Rk has a pending write.

## Operation

- Registers: sixteen N-bit flops. Outputs are driven directly from the flops; there is no write-to-read bypass.
- Writeback:
  - When we_i = 1 and waddr_i ≠ 15, R[waddr_i] ← wdata_i at the next edge.
  - Writeback to R15 is ignored.
- Link:
  - When link_we_i = 1, R14 ← link_data_i.
  - If we_i = 1 with waddr_i = 14 in the same cycle, the writeback port wins and the link data is dropped.
- PC mirror: R15 ← pc_i on every non-reset edge, unconditionally.
- Scoreboard, evaluated per bit each edge:
  - Clear: busy[waddr_i] ← 0 when we_i = 1; busy[14] ← 0 when link_we_i = 1.
  - Set: busy[reserve_addr_i] ← 1 when reserve_i = 1 and reserve_addr_i ≠ 15.
  - Set beats clear on the same bit in the same cycle, because the newly issued instruction owns the register.
  - busy[15] is constant 0.
  - Writes to a register that is not busy are legal and update data normally.
- Reset (rst_i = 1 at an edge):
  - Every register, including R15, and every busy bit go to 0.
  - Reset overrides all concurrent writes and reserves.
  - Reset asserted mid-operation discards in-flight reservations; no write from that cycle lands.

## Timing

- Write latency: 1 cycle. Data written at edge t is visible on rK_o after edge t and stays stable until the next write to K.
- Reading during a write cycle returns the old value.
- R15 lags pc_i by exactly one cycle.
- Busy latency: busy_o changes one cycle after the reserve or writeback request.
- A register reserved and written back in the same cycle shows busy = 1 and the new data.
- All outputs are 0 from the edge at which rst_i is sampled high until the first edge after rst_i falls.
- No combinational path from any input to any output.

## Test plan

- Reset, then we_i = 1, waddr_i = 3, wdata_i = 0xDEADBEEF for one cycle:
  - r3_o = 0xDEADBEEF one cycle later; all other rK_o (K ≠ 15) stay 0.
  - r3_o still holds 0xDEADBEEF after 10 idle cycles.
- pc_i = 0x100 then 0x104; we_i = 1, waddr_i = 15, wdata_i = 0xFFFFFFFF:
  - r15_o tracks pc_i one cycle behind (0x100, then 0x104) and never shows 0xFFFFFFFF.
- Same cycle: link_we_i = 1, link_data_i = 0x200; we_i = 1, waddr_i = 14, wdata_i = 0x55:
  - r14_o = 0x55. Repeating with we_i = 0 gives r14_o = 0x200 and clears busy[14].
- reserve_i = 1, reserve_addr_i = 5, then two idle cycles, then we_i = 1, waddr_i = 5:
  - busy_o = 0x0020 for three cycles, then 0x0000.
  - Reserve on R15 leaves busy_o = 0x0000.
- Same cycle: reserve_addr_i = 7 with reserve_i = 1, and we_i = 1, waddr_i = 7, wdata_i = 0x77:
  - busy_o[7] = 1 and r7_o = 0x77 one cycle later.
- All sixteen registers written to nonzero values and busy bits set, then rst_i = 1 for one cycle together with we_i = 1:
  - All rK_o = 0 and busy_o = 0x0000 the next cycle; the concurrent write is lost.
